// File: rtl/bc_mem_arbiter.sv
// Single-port memory arbiter sharing main memory between the CPU datapath and a DMA/loader port.
// Round-robin ownership with a bounded burst; read data is routed back to the issuing port one cycle later.
module bc_mem_arbiter #(
  parameter int WORD      = 16,
  parameter int ADDRESS   = 12,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDRESS-1:0] cpu_addr,
  input  logic [WORD-1:0]    cpu_wdata,
  output logic               cpu_gnt,
  output logic               cpu_stall,
  output logic               cpu_rvalid,
  output logic [WORD-1:0]    cpu_rdata,
  input  logic               dma_req,
  input  logic               dma_we,
  input  logic [ADDRESS-1:0] dma_addr,
  input  logic [WORD-1:0]    dma_wdata,
  output logic               dma_gnt,
  output logic               dma_rvalid,
  output logic [WORD-1:0]    dma_rdata,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDRESS-1:0] mem_addr,
  output logic [WORD-1:0]    mem_wdata,
  input  logic [WORD-1:0]    mem_rdata,
  output logic [1:0]         owner
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  owner_t        r_owner;
  owner_t        w_owner_next;
  logic [CW-1:0] r_burst_cnt;
  logic [CW-1:0] w_burst_next;
  logic          r_rr_last_dma;
  logic          w_rr_next;
  logic          r_cpu_rvalid_q;
  logic          r_dma_rvalid_q;
  logic          w_cpu_pick;
  logic          w_dma_pick;
  logic          w_burst_open;

  assign w_burst_open = (r_burst_cnt < BURST_MAX);

  always_comb begin
    w_cpu_pick = 1'b0;
    w_dma_pick = 1'b0;
    if (r_owner == OWN_CPU && cpu_req && (w_burst_open || !dma_req)) begin
      w_cpu_pick = 1'b1;
    end else if (r_owner == OWN_DMA && dma_req && (w_burst_open || !cpu_req)) begin
      w_dma_pick = 1'b1;
    end else if (cpu_req && dma_req) begin
      // Tie goes to whichever port was not granted last.
      w_cpu_pick = r_rr_last_dma;
      w_dma_pick = !r_rr_last_dma;
    end else begin
      w_cpu_pick = cpu_req;
      w_dma_pick = dma_req;
    end
  end

  // Reset gates the grant path so no access can slip out while rst_n is low.
  assign cpu_gnt   = w_cpu_pick & rst_n;
  assign dma_gnt   = w_dma_pick & rst_n;
  assign cpu_stall = cpu_req & ~cpu_gnt;

  assign mem_en    = cpu_gnt | dma_gnt;
  assign mem_we    = (cpu_gnt & cpu_we) | (dma_gnt & dma_we);
  assign mem_addr  = ({ADDRESS{cpu_gnt}} & cpu_addr) | ({ADDRESS{dma_gnt}} & dma_addr);
  assign mem_wdata = ({WORD{cpu_gnt}} & cpu_wdata) | ({WORD{dma_gnt}} & dma_wdata);

  always_comb begin
    w_owner_next = r_owner;
    w_burst_next = r_burst_cnt;
    w_rr_next    = r_rr_last_dma;
    if (mem_en) begin
      w_rr_next    = dma_gnt;
      w_owner_next = dma_gnt ? OWN_DMA : OWN_CPU;
      if (w_owner_next == r_owner) begin
        w_burst_next = (r_burst_cnt == BURST_MAX) ? r_burst_cnt : r_burst_cnt + CW'(1);
      end else begin
        w_burst_next = CW'(1);
      end
    end else begin
      w_owner_next = OWN_NONE;
      w_burst_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner        <= OWN_NONE;
      r_burst_cnt    <= '0;
      r_rr_last_dma  <= 1'b1;
      r_cpu_rvalid_q <= 1'b0;
      r_dma_rvalid_q <= 1'b0;
    end else begin
      r_owner        <= w_owner_next;
      r_burst_cnt    <= w_burst_next;
      r_rr_last_dma  <= w_rr_next;
      r_cpu_rvalid_q <= cpu_gnt & ~cpu_we;
      r_dma_rvalid_q <= dma_gnt & ~dma_we;
    end
  end

  assign owner      = r_owner;
  assign cpu_rvalid = r_cpu_rvalid_q;
  assign dma_rvalid = r_dma_rvalid_q;
  assign cpu_rdata  = r_cpu_rvalid_q ? mem_rdata : '0;
  assign dma_rdata  = r_dma_rvalid_q ? mem_rdata : '0;

endmodule

// File: tb/tb_bc_mem_arbiter.sv
// Scoreboard bench for bc_mem_arbiter: directed per-cycle requests with hand-derived grant owners;
// a negedge monitor checks every memory strobe and every read return against the queued expectations.
module tb_bc_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [11:0] cpu_addr, dma_addr;
  logic [15:0] cpu_wdata, dma_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [15:0] cpu_rdata, dma_rdata;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic [1:0]  owner;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  typedef struct {
    int          cyc;
    logic [1:0]  port;
    logic        we;
    logic [11:0] addr;
    logic [15:0] wdata;
  } gexp_t;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq_cpu[$];
  rexp_t rq_dma[$];

  bc_mem_arbiter #(.WORD(16), .ADDRESS(12), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_model(input logic [11:0] a);
    return 16'hBEE0 + 16'(a) * 16'd3;
  endfunction

  // Memory returns data one cycle after a read strobe.
  always @(posedge clk) mem_rdata <= (mem_en && !mem_we) ? mem_model(mem_addr) : 16'h0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
  endtask

  // One cycle of stimulus; exp: 0 = no grant, 1 = CPU, 2 = DMA.
  task automatic step(input logic cr, input logic cw, input logic [11:0] ca, input logic [15:0] cd,
                      input logic dr, input logic dw, input logic [11:0] da, input logic [15:0] dd,
                      input int exp);
    gexp_t g;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    if (exp != 0) begin
      g.cyc   = cyc;
      g.port  = 2'(exp);
      g.we    = (exp == 1) ? cw : dw;
      g.addr  = (exp == 1) ? ca : da;
      g.wdata = (exp == 1) ? cd : dd;
      gq.push_back(g);
      if (!g.we) begin
        if (exp == 1) rq_cpu.push_back('{cyc + 1, mem_model(ca)});
        else          rq_dma.push_back('{cyc + 1, mem_model(da)});
      end
    end
    $display("cyc=%0d rst_n=%0b cpu(req=%0b we=%0b a=%h) dma(req=%0b we=%0b a=%h) expect_grant=%0d",
             cyc, rst_n, cr, cw, ca, dr, dw, da, exp);
    #1;
    chk("cpu_stall", 32'(cpu_stall), 32'(cr && exp != 1));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0, 0);
  endtask

  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    if (gq.size() > 0 && gq[0].cyc == cyc) begin
      g = gq.pop_front();
      chk("mem_en", 32'(mem_en), 32'd1);
      chk("grant_port", 32'({dma_gnt, cpu_gnt}), 32'(g.port));
      chk("mem_access", {3'b0, mem_we, mem_addr, mem_wdata}, {3'b0, g.we, g.addr, g.wdata});
    end else begin
      chk("no_grant", 32'({mem_en, dma_gnt, cpu_gnt}), 32'd0);
    end
    if (rq_cpu.size() > 0 && rq_cpu[0].cyc == cyc) begin
      r = rq_cpu.pop_front();
      chk("cpu_read", {15'b0, cpu_rvalid, cpu_rdata}, {15'b0, 1'b1, r.data});
    end else begin
      chk("cpu_no_read", {15'b0, cpu_rvalid, cpu_rdata}, 32'd0);
    end
    if (rq_dma.size() > 0 && rq_dma[0].cyc == cyc) begin
      r = rq_dma.pop_front();
      chk("dma_read", {15'b0, dma_rvalid, dma_rdata}, {15'b0, 1'b1, r.data});
    end else begin
      chk("dma_no_read", {15'b0, dma_rvalid, dma_rdata}, 32'd0);
    end
  end

  initial begin
    int pa[10];
    int pd_exp[10];
    logic pd_cr[10];
    int d;
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    @(posedge clk);
    #1;

    // Reset held with both ports requesting: nothing granted, CPU stalled.
    repeat (2) step(1, 0, 12'h001, 16'h0, 1, 0, 12'h201, 16'h0, 0);
    chk("owner_in_reset", 32'(owner), 32'd0);

    // Both read every cycle from idle: CPU wins the first tie, then bursts of 4 alternate.
    rst_n = 1'b1;
    pa = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1};
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 12'h010 + 12'(i), 16'h0, 1, 0, 12'h020 + 12'(i), 16'h0, pa[i]);
      if (i == 0) chk("owner_after_first", 32'(owner), 32'd1);
    end
    idle();
    chk("owner_idle", 32'(owner), 32'd0);

    // Uncontended CPU read of 0x005 returns 0xBEEF next cycle.
    step(1, 0, 12'h005, 16'h0, 0, 0, 12'h0, 16'h0, 1);
    idle();

    // DMA alone writes 10 words: 10 consecutive grants despite burst saturation.
    for (int i = 0; i < 10; i++)
      step(0, 0, 12'h0, 16'h0, 1, 1, 12'h300 + 12'(i), 16'h1000 + 16'(i), 2);
    chk("owner_dma_sat", 32'(owner), 32'd2);
    idle();

    // DMA writes, CPU joins at k=2: DMA finishes its 4-grant burst, CPU takes over, CPU drops at k=7.
    pd_cr  = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0};
    pd_exp = '{2, 2, 2, 2, 1, 1, 1, 2, 2, 2};
    d = 0;
    for (int k = 0; k < 10; k++) begin
      step(pd_cr[k], k == 2, (k == 2) ? 12'h0AA : 12'h0B0 + 12'(k), 16'h5555,
           1, 1, 12'h100 + 12'(d), 16'hD000 + 16'(d), pd_exp[k]);
      if (pd_exp[k] == 2) d++;
    end
    idle();

    // Reset the cycle after a CPU read grant: rvalid drops at once and never returns.
    step(1, 0, 12'h0C0, 16'h0, 0, 0, 12'h0, 16'h0, 1);
    rst_n = 1'b0;
    void'(rq_cpu.pop_back());
    #1;
    chk("rvalid_reset", {15'b0, cpu_rvalid, cpu_rdata}, 32'd0);
    repeat (2) step(1, 0, 12'h0C1, 16'h0, 1, 0, 12'h0D1, 16'h0, 0);
    chk("owner_reset2", 32'(owner), 32'd0);
    rst_n = 1'b1;
    repeat (3) idle();

    // rr_last was cleared to DMA, so the CPU wins the tie again.
    step(1, 0, 12'h0E0, 16'h0, 1, 0, 12'h0F0, 16'h0, 1);
    repeat (2) idle();

    chk("grant_queue_empty", 32'(gq.size()), 32'd0);
    chk("read_queues_empty", 32'(rq_cpu.size() + rq_dma.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bc_mem_arbiter.md
# bc_mem_arbiter

Single-port memory arbiter that shares the 4096×16 main memory between the Basic Computer CPU datapath and a DMA/program-loader port. Each cycle it grants at most one requester, drives the memory port from the winner, and returns read data one cycle later to the port that issued the read. A round-robin policy with a bounded burst counter ensures neither requester starves. It sits between the datapath's memory access path and the memory array. The CPU controller holds its current T-state while `cpu_stall` is high.

## Interface
- `WORD`, 16, data width
- `ADDRESS`, 12, address width
- `MAX_BURST`, 4, maximum consecutive grants to one owner while the other port is requesting (≥1)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `cpu_req`  in  1  CPU access request
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDRESS  CPU address
- `cpu_wdata`  in  WORD  CPU write data
- `cpu_gnt`  out  1  CPU access performed this cycle
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`
- `cpu_rvalid`  out  1  CPU read data valid
- `cpu_rdata`  out  WORD  CPU read data
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_gnt`, `dma_rvalid`, `dma_rdata`  same as the CPU equivalents, for the DMA port
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDRESS  memory address
- `mem_wdata`  out  WORD  memory write data
- `mem_rdata`  in  WORD  memory read data, valid the cycle after a read strobe
- `owner`  out  2  registered owner: 0 = NONE, 1 = CPU, 2 = DMA

## Operation
- **Registered state**
  - `owner` ∈ {NONE, CPU, DMA}.
  - `burst_cnt` (width clog2(MAX_BURST+1)).
  - `rr_last`: last granted port.
  - `cpu_rvalid_q`, `dma_rvalid_q`.
- **Grant decision** (combinational, from the registered state and the current requests), evaluated in priority order:
  1. If `owner` is a port P, `P_req`=1, and (`burst_cnt` < MAX_BURST or the other port's `req`=0): grant P.
  2. Otherwise, if exactly one port requests: grant it.
  3. Otherwise, if both request: grant the port ≠ `rr_last`.
  4. Otherwise: no grant.
- **Memory drive**
  - `mem_en` = any grant.
  - `mem_we`, `mem_addr`, `mem_wdata` are muxed from the granted port.
  - With no grant, all memory outputs are 0.
- **State update at the clock edge**
  - Grant to the same port as `owner`: `burst_cnt` = min(`burst_cnt`+1, MAX_BURST).
  - Grant to a different port, or from NONE: `burst_cnt` = 1 and `owner` = granted port.
  - No grant: `owner` = NONE and `burst_cnt` = 0; `rr_last` is unchanged.
  - Any grant: `rr_last` = granted port.
- **Read return**
  - `P_rvalid` is set for one cycle after a granted read (`P_gnt` & ~`P_we`).
  - `P_rdata` = `mem_rdata` when `P_rvalid`=1, else 0.
- **Writes**
  - Complete at the granting edge.
  - Produce no `rvalid`.
- **Boundary conditions**
  - Burst limit reached while the other port is idle: the owner keeps the grant; `burst_cnt` stays saturated at MAX_BURST.
  - Owner drops `req`: the other port is granted in the same cycle if it is requesting (rule 2).
  - Back-to-back reads by alternating ports: each `rvalid` is routed to the correct port with no gap.
  - Requester changes `addr`/`we` while stalled: the values sampled in the grant cycle are the ones used.
  - Reset mid-access:
    - All state clears asynchronously.
    - Grants, `mem_en`, and `rvalid` drop immediately.
    - A pending read never returns.

## Timing
- **While `rst_n`=0**
  - `cpu_gnt` = `dma_gnt` = `mem_en` = 0; `cpu_stall` = `cpu_req`.
  - `owner` = NONE, `burst_cnt` = 0, `rr_last` = DMA (so the CPU wins the first tie).
  - Both `rvalid` = 0; both `rdata` = 0.
- **Grant latency**
  - 0 cycles when uncontended.
  - Worst case MAX_BURST cycles when the other port is bursting.
- **Read latency**: `rvalid`/`rdata` appear exactly 1 cycle after the grant cycle.
- **Throughput**: one access per cycle; no idle cycle is inserted when ownership switches.

## Test plan
- **Reset**: assert `rst_n`=0 with both `req`=1 → both `gnt`=0, `mem_en`=0, `owner`=0, `cpu_stall`=1. Release reset → CPU granted first; `owner`=1 after the edge.
- **Uncontended read**: CPU reads 0x005 with `mem_rdata`=0xBEEF in the following cycle → `cpu_gnt`=1 in cycle 0; `cpu_rvalid`=1 with `cpu_rdata`=0xBEEF in cycle 1; `dma_rvalid`=0.
- **Burst limit** (MAX_BURST=4): DMA owns the port and writes 0x100–0x10F continuously, then the CPU asserts `req` → DMA gets at most 4 consecutive grants counted from its burst start. The CPU is granted in the next cycle, then DMA resumes after the CPU's burst or when the CPU drops `req`.
- **Saturation**: DMA alone writes 10 consecutive words → 10 consecutive grants, `burst_cnt` held at 4, `cpu_stall` never asserted.
- **Alternating reads**: both ports request reads every cycle from idle → grants alternate per the round-robin and burst rules. Each returned word appears only on the issuing port's `rdata`, with `rvalid` one cycle after its grant.
- **Reset mid-read**: drop `rst_n` the cycle after a CPU read grant → `cpu_rvalid` is forced to 0 immediately and does not assert after release.
